// File: rtl/pll_reset_seq.sv
// ---------------------------------------------------------------------------
// pll_reset_seq
//
// Power-up and recovery sequencer for the DCM PLL and the three per-domain
// reset synchronizers (mclk, cam_clk, pclk). Runs on the free-running
// reference clock.
//
// Sequence: hold the DCM in reset, wait for lock, require lock to stay
// stable, then release the mclk, cam_clk and pclk reset requests in that
// order with a fixed gap between them. A lock timeout retries a bounded
// number of times before giving up (sticky fail). Losing lock at any point
// after the first release re-asserts every domain reset at once and starts
// over from the DCM reset.
//
// Ports:
//   clk              in   reference clock, rising edge
//   reset_n          in   asynchronous active-low reset (already filtered)
//   lock_in          in   DCM LOCKED, asynchronous; 2-flop synchronized
//   restart          in   single-cycle synchronous restart request
//   dcm_rst          out  active-high reset to the DCM
//   mreset_req_n     out  mclk domain reset request, active-low
//   cam_reset_req_n  out  cam_clk domain reset request, active-low
//   preset_req_n     out  pclk domain reset request, active-low
//   ready            out  all domains released and PLL locked
//   fail             out  retries exhausted; sticky until restart/reset
//   retry_cnt        out  retries used in the current sequence (sat. 15)
// ---------------------------------------------------------------------------
module pll_reset_seq #(
  parameter int unsigned RST_HOLD     = 16,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned LOCK_STABLE  = 64,
  parameter int unsigned REL_GAP      = 8,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned CNT_W        = 13
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       lock_in,
  input  logic       restart,
  output logic       dcm_rst,
  output logic       mreset_req_n,
  output logic       cam_reset_req_n,
  output logic       preset_req_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt
);

  // The release states are declared in release order and directly before
  // RUN, so "domain released" reduces to a range compare on the state.
  typedef enum logic [2:0] {
    ST_RST_ASSERT,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_REL_M,
    ST_REL_CAM,
    ST_REL_P,
    ST_RUN,
    ST_FAIL
  } state_t;

  // Terminal counts: a state of duration N leaves on the edge where cnt==N-1.
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(REL_GAP - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

  // First state in which each domain (0=mclk, 1=cam_clk, 2=pclk) is released.
  localparam state_t REL_FIRST [3] = '{ST_REL_M, ST_REL_CAM, ST_REL_P};

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       retry_reg, retry_next;
  logic [1:0]       sync_reg;
  logic             lock_s;

  logic             dcm_rst_reg, dcm_rst_next;
  logic [2:0]       rel_reg, rel_next;
  logic             ready_reg, ready_next;
  logic             fail_reg, fail_next;

  // -------------------------------------------------------------------------
  // Lock synchronizer. A sub-cycle glitch on lock_in may be missed here;
  // the STABLE window filters anything that does get through.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], lock_in};
    end
  end

  assign lock_s = sync_reg[1];

  // -------------------------------------------------------------------------
  // State, counter and registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_RST_ASSERT;
      cnt_reg     <= '0;
      retry_reg   <= 4'd0;
      dcm_rst_reg <= 1'b1;
      rel_reg     <= 3'b000;
      ready_reg   <= 1'b0;
      fail_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      retry_reg   <= retry_next;
      dcm_rst_reg <= dcm_rst_next;
      rel_reg     <= rel_next;
      ready_reg   <= ready_next;
      fail_reg    <= fail_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. restart outranks every other exit condition.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;

    if (restart) begin
      state_next = ST_RST_ASSERT;
      retry_next = 4'd0;
    end else begin
      unique case (state_reg)
        ST_RST_ASSERT: begin
          if (cnt_reg == HOLD_LAST) begin
            state_next = ST_WAIT_LOCK;
          end
        end

        ST_WAIT_LOCK: begin
          // Lock arriving on the timeout edge still wins over the retry.
          if (lock_s) begin
            state_next = ST_STABLE;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            if (retry_reg == RETRY_LIMIT) begin
              state_next = ST_FAIL;
            end else begin
              state_next = ST_RST_ASSERT;
              retry_next = (retry_reg == 4'hF) ? retry_reg : retry_reg + 4'd1;
            end
          end
        end

        ST_STABLE: begin
          // A dropout here only reopens the lock window; it is not a retry.
          if (!lock_s) begin
            state_next = ST_WAIT_LOCK;
          end else if (cnt_reg == STABLE_LAST) begin
            state_next = ST_REL_M;
          end
        end

        ST_REL_M: begin
          if (!lock_s) begin
            state_next = ST_RST_ASSERT;
          end else if (cnt_reg == GAP_LAST) begin
            state_next = ST_REL_CAM;
          end
        end

        ST_REL_CAM: begin
          if (!lock_s) begin
            state_next = ST_RST_ASSERT;
          end else if (cnt_reg == GAP_LAST) begin
            state_next = ST_REL_P;
          end
        end

        ST_REL_P: begin
          if (!lock_s) begin
            state_next = ST_RST_ASSERT;
          end else begin
            state_next = ST_RUN;
            retry_next = 4'd0;
          end
        end

        ST_RUN: begin
          if (!lock_s) begin
            state_next = ST_RST_ASSERT;
          end
        end

        ST_FAIL: begin
          state_next = ST_FAIL;
        end

        default: begin
          state_next = ST_RST_ASSERT;
        end
      endcase
    end
  end

  // The counter restarts on every state entry, including a restart that
  // re-enters RST_ASSERT from itself. RUN and FAIL have no timed exit, so
  // the counter is frozen there.
  always_comb begin
    cnt_next = cnt_reg;
    if (restart || (state_next != state_reg)) begin
      cnt_next = '0;
    end else if ((state_reg != ST_RUN) && (state_reg != ST_FAIL)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode from the next state, so the output registers always match
  // the state register and all re-assertions land on the same edge.
  // -------------------------------------------------------------------------
  always_comb begin
    dcm_rst_next = (state_next == ST_RST_ASSERT) || (state_next == ST_FAIL);
    ready_next   = (state_next == ST_REL_P) || (state_next == ST_RUN);
    fail_next    = (state_next == ST_FAIL);
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_rel
    assign rel_next[gi] = (state_next >= REL_FIRST[gi]) && (state_next <= ST_RUN);
  end

  assign dcm_rst         = dcm_rst_reg;
  assign mreset_req_n    = rel_reg[0];
  assign cam_reset_req_n = rel_reg[1];
  assign preset_req_n    = rel_reg[2];
  assign ready           = ready_reg;
  assign fail            = fail_reg;
  assign retry_cnt       = retry_reg;

endmodule
